// File: rtl/npu_mac_pkg.sv
// Shared types and constant helpers for the NPU dot-product MAC.
package npu_mac_pkg;

    typedef enum logic {
        MODE_DOT = 1'b0,
        MODE_ACC = 1'b1
    } mode_e;

    // Saturation limits are built at this width, then truncated to ACC_W by the caller.
    localparam int SAT_FN_W = 128;

    function automatic int tree_depth(input int lanes);
        return $clog2(lanes);
    endfunction

    function automatic logic [SAT_FN_W-1:0] sat_max(input int acc_w);
        return (SAT_FN_W'(1) << (acc_w - 1)) - SAT_FN_W'(1);
    endfunction

    function automatic logic [SAT_FN_W-1:0] sat_min(input int acc_w);
        return {SAT_FN_W{1'b1}} << (acc_w - 1);
    endfunction

endpackage

// File: rtl/npu_adder_tree.sv
// Registered signed adder tree: one pipeline level per halving, each level one bit wider.
// Valid and sideband bits travel alongside the partial sums.
module npu_adder_tree
    import npu_mac_pkg::*;
#(
    parameter int LANES = 4,
    parameter int IN_W  = 36,
    parameter int SB_W  = 3,
    localparam int T     = tree_depth(LANES),
    localparam int OUT_W = IN_W + T
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic [SB_W-1:0]         in_sb,
    input  logic [LANES*IN_W-1:0]   in_data,
    output logic                    out_valid,
    output logic [SB_W-1:0]         out_sb,
    output logic signed [OUT_W-1:0] out_sum
);

    for (genvar gl = 0; gl < T; gl++) begin : g_lvl
        localparam int OW = IN_W + gl + 1;
        localparam int N  = LANES >> (gl + 1);

        logic signed [OW-1:0] sum_d [N];
        logic signed [OW-1:0] sum_q [N];
        logic                 valid_d;
        logic                 valid_q;
        logic [SB_W-1:0]      sb_d;
        logic [SB_W-1:0]      sb_q;

        if (gl == 0) begin : g_leaf
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    sum_d[i] = OW'($signed(in_data[(2*i)*IN_W +: IN_W]))
                             + OW'($signed(in_data[(2*i+1)*IN_W +: IN_W]));
                end
                valid_d = in_valid;
                sb_d    = in_sb;
            end
        end else begin : g_node
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    sum_d[i] = OW'(g_lvl[gl-1].sum_q[2*i]) + OW'(g_lvl[gl-1].sum_q[2*i+1]);
                end
                valid_d = g_lvl[gl-1].valid_q;
                sb_d    = g_lvl[gl-1].sb_q;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < N; i++) begin
                    sum_q[i] <= '0;
                end
                valid_q <= 1'b0;
                sb_q    <= '0;
            end else if (ce) begin
                for (int i = 0; i < N; i++) begin
                    sum_q[i] <= sum_d[i];
                end
                valid_q <= valid_d;
                sb_q    <= sb_d;
            end
        end
    end

    assign out_sum   = g_lvl[T-1].sum_q[0];
    assign out_valid = g_lvl[T-1].valid_q;
    assign out_sb    = g_lvl[T-1].sb_q;

endmodule

// File: rtl/npu_dot_mac.sv
// Pipelined signed LANES-wide dot product with optional multi-beat accumulation,
// saturating or wrapping accumulate and a sticky per-group overflow flag.
module npu_dot_mac
    import npu_mac_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int A_W      = 18,
    parameter int B_W      = 18,
    parameter int ACC_W    = 48,
    parameter bit SATURATE = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic                    in_mode,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [LANES*A_W-1:0]    a_in,
    input  logic [LANES*B_W-1:0]    b_in,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] dout,
    output logic                    ovf
);

    localparam int T     = tree_depth(LANES);
    localparam int PW    = A_W + B_W;
    localparam int SUM_W = PW + T;
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

    if (ACC_W < SUM_W) begin : g_acc_too_narrow
        $error("npu_dot_mac: ACC_W too small for A_W+B_W+log2(LANES)");
    end
    if ((LANES < 2) || ((LANES & (LANES - 1)) != 0)) begin : g_bad_lanes
        $error("npu_dot_mac: LANES must be a power of two >= 2");
    end

    // Input stage
    logic signed [A_W-1:0] a_d [LANES];
    logic signed [A_W-1:0] a_q [LANES];
    logic signed [B_W-1:0] b_d [LANES];
    logic signed [B_W-1:0] b_q [LANES];
    logic  s0_valid_d, s0_valid_q;
    mode_e s0_mode_d,  s0_mode_q;
    logic  s0_first_d, s0_first_q;
    logic  s0_last_d,  s0_last_q;

    // Product stage
    logic signed [PW-1:0]   prod_d [LANES];
    logic signed [PW-1:0]   prod_q [LANES];
    logic [LANES*PW-1:0]    prod_flat;
    logic                   s1_valid_d, s1_valid_q;
    logic [2:0]             s1_sb_d, s1_sb_q;

    // Tree outputs
    logic                    t_valid;
    logic [2:0]              t_sb;
    logic signed [SUM_W-1:0] tree_sum;
    mode_e                   t_mode;
    logic                    t_first;
    logic                    t_last;

    // Accumulate / output stage
    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic                    sticky_d, sticky_q;
    logic signed [ACC_W-1:0] dout_d, dout_q;
    logic                    ovf_d, ovf_q;
    logic                    out_valid_d, out_valid_q;
    logic signed [ACC_W-1:0] sum_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    add_ovf;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            a_d[i]    = a_in[i*A_W +: A_W];
            b_d[i]    = b_in[i*B_W +: B_W];
            prod_d[i] = PW'(a_q[i]) * PW'(b_q[i]);
        end
        s0_valid_d = in_valid;
        s0_mode_d  = mode_e'(in_mode);
        s0_first_d = in_first;
        s0_last_d  = in_last;
        s1_valid_d = s0_valid_q;
        s1_sb_d    = {s0_mode_q, s0_first_q, s0_last_q};
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_pack
        assign prod_flat[gi*PW +: PW] = prod_q[gi];
    end

    npu_adder_tree #(
        .LANES (LANES),
        .IN_W  (PW),
        .SB_W  (3)
    ) u_tree (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (s1_valid_q),
        .in_sb     (s1_sb_q),
        .in_data   (prod_flat),
        .out_valid (t_valid),
        .out_sb    (t_sb),
        .out_sum   (tree_sum)
    );

    assign t_mode  = mode_e'(t_sb[2]);
    assign t_first = t_sb[1];
    assign t_last  = t_sb[0];

    always_comb begin
        sum_ext = ACC_W'(tree_sum);
        acc_sum = acc_q + sum_ext;
        // Signed overflow: operands agree in sign, result does not.
        add_ovf = (acc_q[ACC_W-1] == sum_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

        acc_d       = acc_q;
        sticky_d    = sticky_q;
        dout_d      = dout_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;

        if (t_valid) begin
            if (t_mode == MODE_DOT) begin
                dout_d      = sum_ext;
                ovf_d       = 1'b0;
                out_valid_d = 1'b1;
            end else begin
                if (t_first) begin
                    acc_d    = sum_ext;
                    sticky_d = 1'b0;
                end else if (add_ovf) begin
                    sticky_d = 1'b1;
                    if (SATURATE) begin
                        acc_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
                    end else begin
                        acc_d = acc_sum;
                    end
                end else begin
                    acc_d = acc_sum;
                end
                if (t_last) begin
                    out_valid_d = 1'b1;
                    dout_d      = acc_d;
                    ovf_d       = sticky_d;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                a_q[i]    <= '0;
                b_q[i]    <= '0;
                prod_q[i] <= '0;
            end
            s0_valid_q  <= 1'b0;
            s0_mode_q   <= MODE_DOT;
            s0_first_q  <= 1'b0;
            s0_last_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_sb_q     <= '0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (ce) begin
            for (int i = 0; i < LANES; i++) begin
                a_q[i]    <= a_d[i];
                b_q[i]    <= b_d[i];
                prod_q[i] <= prod_d[i];
            end
            s0_valid_q  <= s0_valid_d;
            s0_mode_q   <= s0_mode_d;
            s0_first_q  <= s0_first_d;
            s0_last_q   <= s0_last_d;
            s1_valid_q  <= s1_valid_d;
            s1_sb_q     <= s1_sb_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            dout_q      <= dout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/npu_dot_mac.md
Name: npu_dot_mac

Overview:
Parametrised, pipelined signed dot-product unit for the NPU datapath. It generalises the two-lane DSP multiply-add (a0*b0 + a1*b1) to LANES lanes. It adds a registered adder tree, a per-beat mode select (single dot product or multi-beat accumulate), selectable saturation, an overflow flag and valid tracking through the pipeline. It sits between the operand fetch buffers and the activation/requantise stage.

Parameters:
LANES, 4, number of multiply lanes; power of two, >= 2
A_W, 18, signed width of each A operand
B_W, 18, signed width of each B operand
ACC_W, 48, signed accumulator/output width; elaboration error if ACC_W < A_W+B_W+log2(LANES)
SATURATE, 1, 1 = clamp on accumulate overflow; 0 = two's-complement wrap

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-high; clears all state
ce  in  1  clock enable; 0 freezes the entire pipeline, including valids and accumulator
in_valid  in  1  beat qualifier
in_mode  in  1  0 = single dot product, 1 = accumulate
in_first  in  1  mode 1 only: first beat of a group
in_last  in  1  mode 1 only: last beat of a group
a_in  in  LANES*A_W  packed signed operands; lane i at [i*A_W +: A_W]
b_in  in  LANES*B_W  packed signed operands; lane i at [i*B_W +: B_W]
out_valid  out  1  dout/ovf valid; single-cycle pulse per result
dout  out  ACC_W  signed result
ovf  out  1  result overflowed (clamped or wrapped)

Behaviour:
- Reset: out_valid=0, dout=0, ovf=0, accumulator=0, all pipeline valid bits=0. Async assert, released synchronously to clk by the upstream reset synchroniser.
- Pipeline: S0 input reg; S1 product reg (A_W+B_W bits per lane); T=log2(LANES) tree stages, each level widening by 1 bit; S_out accumulate/output reg.
- Latency: LAT = 3+T rising edges with ce=1, counting the sampling edge as edge 1. LANES=4 gives LAT=5. Full throughput: one beat per ce cycle.
- mode/first/last/valid travel with the data. Control is never sampled late.
- Tree sum is sign-extended to ACC_W.
- Mode 0 beat: dout = tree sum, ovf=0, out_valid pulses. The accumulator is untouched, even inside an open mode-1 group.
- Mode 1 beat with first=1: acc = sum, and the group ovf sticky is cleared then set by this add.
- Mode 1 beat with first=0: acc = acc + sum. On signed overflow:
  - SATURATE=1: clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1), and set the sticky.
  - SATURATE=0: wrap, and set the sticky.
- Mode 1 beat with last=1: out_valid pulses with dout = updated acc and ovf = sticky. Beats with last=0 produce no output.
- first=last=1: single-beat group; the output is that beat's sum.
- first=1 while a group is open: the old group is discarded silently with no output; the new group starts.
- Mode 1 beats arriving before any first=1 after reset accumulate onto 0.
- in_valid=0 beats change nothing except advancing empty bubbles.
- ce=0: every register holds; out_valid stays as is (the result is held, not re-pulsed when ce returns).
- Reset mid-group or mid-flight: all in-flight beats are dropped; no output appears for them.

Decomposition:
- Package npu_mac_pkg holds:
  - mode typedef (MODE_DOT=0, MODE_ACC=1)
  - function for tree depth (clog2)
  - saturation-limit constant functions of ACC_W
- Sub-module npu_adder_tree: parametrised LANES-input registered signed tree, with ce and a valid/sideband shift of depth T.
- The top holds input regs, multipliers (inferred to DSP) and the accumulate/saturate stage.

Test Plan:
1. Reset held 10 cycles with random inputs -> out_valid=0, dout=0, ovf=0 throughout. First beat after release is processed normally.
2. Mode 0, a={1,2,3,4}, b={5,6,7,8} -> dout=70, out_valid exactly on edge 5. Back-to-back random beats match a signed reference model each cycle (1000 beats).
3. Mode 0, all a=b=-131072 -> dout=68719476736 (2^36), ovf=0. Mixed sign a={-131072,131071,0,-1}, b={131071,-131072,5,-1} -> dout=-34359476223.
4. Mode 1, three beats (first, mid, last), all a=1 and all b=2 -> one out_valid, dout=24. A mode 0 beat inserted mid-group emits 8 and the group result is still 24.
5. ACC_W=38, two-beat group, all operands -131072:
   - SATURATE=1 -> dout=137438953471, ovf=1.
   - SATURATE=0 -> dout=-137438953472, ovf=1.
   - Next group without overflow -> ovf=0.
6. ce deasserted 3 cycles mid-flight -> result delayed exactly 3 cycles with unchanged value. Reset pulsed mid-group -> no output for that group; a subsequent first/last group of sum 8 gives dout=8.
